// File: rtl/adc_capture_fifo.sv
// adc_capture_fifo
//
// Deserialises the ADC serial stream into SAMPLE_W-bit samples (MSB first),
// packs two samples per 32-bit word (first sample in [31:16]) and buffers the
// words in a DEPTH-entry FIFO that the host pipe-out drains one word per rd.
// Everything runs on clk; the ADC bit clock and data are synchronised in.
//
// Ports
//   clk          block clock
//   rst_n        asynchronous active-low reset
//   enable       level: high arms/runs a capture, low aborts or returns to idle
//   clear        one-cycle pulse: empties FIFO, clears sticky flags and done
//   n_samples    samples per run, latched on the enable rising edge
//   clk_s_d_out  ADC serial bit clock (asynchronous)
//   adc_dout     ADC serial data, valid at the clk_s_d_out rising edge
//   rd           pop strobe, one word per cycle asserted
//   data_out     last popped word
//   word_count   words held in the FIFO
//   empty, full  registered FIFO status
//   overflow     sticky: a packed word was dropped because the FIFO was full
//   underflow    sticky: rd seen while the FIFO was empty
//   busy         capture or flush in progress
//   done         run complete, every sample written to the FIFO
module adc_capture_fifo #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned CNT_W    = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic [31:0]       n_samples,
  input  logic              clk_s_d_out,
  input  logic              adc_dout,
  input  logic              rd,
  output logic [31:0]       data_out,
  output logic [CNT_W-1:0]  word_count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCapture = 2'd1;
  localparam logic [1:0] StFlush   = 2'd2;
  localparam logic [1:0] StDone    = 2'd3;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Clock and data take the same two-flop path so the
  // data bit seen at the detected edge is the one that was on the pin with it.
  // ---------------------------------------------------------------------------
  logic [1:0] sclk_sync_q;
  logic       sclk_prev_q;
  logic [1:0] sdat_sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      sdat_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], clk_s_d_out};
      sclk_prev_q <= sclk_sync_q[1];
      sdat_sync_q <= {sdat_sync_q[0], adc_dout};
    end
  end

  logic bit_edge;
  logic bit_val;
  assign bit_edge = sclk_sync_q[1] & ~sclk_prev_q;
  assign bit_val  = sdat_sync_q[1];

  // ---------------------------------------------------------------------------
  // Capture FSM and packer
  // ---------------------------------------------------------------------------
  logic [1:0]          state_q, state_d;
  logic                en_q;
  logic [31:0]         n_lat_q, n_lat_d;
  logic [31:0]         smp_cnt_q, smp_cnt_d;
  logic [4:0]          bit_cnt_q, bit_cnt_d;
  logic [SAMPLE_W-1:0] shift_q, shift_d;
  logic [31:0]         word_q, word_d;
  logic                half_q, half_d;
  logic                wr_pend_q, wr_pend_d;

  logic                en_rise;
  logic [SAMPLE_W-1:0] shift_nxt;
  logic [15:0]         sample;
  logic                smp_last;
  logic                wr_en;
  logic [31:0]         wr_data;

  assign en_rise   = enable & ~en_q;
  // Older bits fall off the top, so after SAMPLE_W shifts the register holds
  // exactly one sample.
  assign shift_nxt = SAMPLE_W'({shift_q, bit_val});
  assign sample    = 16'(shift_nxt);
  assign smp_last  = (smp_cnt_q + 32'd1) == n_lat_q;

  always_comb begin
    state_d   = state_q;
    n_lat_d   = n_lat_q;
    smp_cnt_d = smp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    word_d    = word_q;
    half_d    = half_q;
    wr_pend_d = 1'b0;
    wr_en     = wr_pend_q;
    wr_data   = word_q;

    case (state_q)
      StIdle: begin
        if (en_rise) begin
          n_lat_d   = n_samples;
          smp_cnt_d = '0;
          bit_cnt_d = '0;
          half_d    = 1'b0;
          state_d   = (n_samples == 32'd0) ? StDone : StCapture;
        end
      end
      StCapture: begin
        if (!enable) begin
          state_d = StIdle;
          half_d  = 1'b0;
        end else if (smp_cnt_q == n_lat_q) begin
          // Even count: the final pair is being written this cycle.
          state_d = StDone;
        end else if (bit_edge) begin
          shift_d = shift_nxt;
          if (bit_cnt_q == 5'(SAMPLE_W - 1)) begin
            bit_cnt_d = '0;
            smp_cnt_d = smp_cnt_q + 32'd1;
            if (!half_q) begin
              word_d[31:16] = sample;
              half_d        = 1'b1;
              if (smp_last) begin
                state_d = StFlush;
              end
            end else begin
              word_d[15:0] = sample;
              half_d       = 1'b0;
              wr_pend_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
      end
      StFlush: begin
        if (!enable) begin
          state_d = StIdle;
        end else begin
          wr_en   = 1'b1;
          wr_data = {word_q[31:16], 16'h0000};
          state_d = StDone;
        end
        half_d = 1'b0;
      end
      StDone: begin
        if (!enable) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (clear) begin
      state_d   = StIdle;
      half_d    = 1'b0;
      wr_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      n_lat_q   <= '0;
      smp_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      half_q    <= 1'b0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= enable;
      n_lat_q   <= n_lat_d;
      smp_cnt_q <= smp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      half_q    <= half_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [31:0]      mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [31:0]      dout_q, dout_d;
  logic             do_wr;
  logic             do_rd;

  // clear wins over a same-cycle write or pop.
  assign do_wr = wr_en & ~full_q & ~clear;
  assign do_rd = rd & ~empty_q & ~clear;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_en & full_q);
    udf_d    = udf_q | (rd & empty_q);
    dout_d   = dout_q;

    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      dout_q   <= dout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign data_out   = dout_q;
  assign word_count = count_q;
  assign empty      = empty_q;
  assign full       = full_q;
  assign overflow   = ovf_q;
  assign underflow  = udf_q;
  assign busy       = (state_q == StCapture) | (state_q == StFlush);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_adc_capture_fifo.sv
// Directed bench for adc_capture_fifo with a 4-word FIFO and 16-bit samples.
module tb_adc_capture_fifo;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        clear;
  logic [31:0] n_samples;
  logic        clk_s_d_out;
  logic        adc_dout;
  logic        rd;
  logic [31:0] data_out;
  logic [2:0]  word_count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  adc_capture_fifo #(
    .SAMPLE_W (16),
    .DEPTH    (4),
    .CNT_W    (3)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clear       (clear),
    .n_samples   (n_samples),
    .clk_s_d_out (clk_s_d_out),
    .adc_dout    (adc_dout),
    .rd          (rd),
    .data_out    (data_out),
    .word_count  (word_count),
    .empty       (empty),
    .full        (full),
    .overflow    (overflow),
    .underflow   (underflow),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word count and the count one cycle earlier, captured when done rises.
  logic       done_prev = 1'b0;
  logic [2:0] cnt_prev  = '0;
  logic [2:0] rise_cnt  = '0;
  logic [2:0] rise_prev = '0;

  always @(negedge clk) begin
    if (done && !done_prev) begin
      rise_cnt  <= word_count;
      rise_prev <= cnt_prev;
    end
    done_prev <= done;
    cnt_prev  <= word_count;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // {empty, full, overflow, underflow, busy, done}
  function automatic logic [31:0] status();
    return {26'd0, empty, full, overflow, underflow, busy, done};
  endfunction

  // One serial bit; the data is set well before and held well after the rising edge.
  // With rd_at_write set, rd is raised for the cycle in which the word completed by
  // this bit is written: the bit is sampled 3 edges after the pin rises, the write
  // issues on the 4th.
  task automatic send_bit(input logic b, input bit rd_at_write);
    @(negedge clk) adc_dout = b;
    repeat (2) @(negedge clk);
    clk_s_d_out = 1'b1;
    if (rd_at_write) begin
      repeat (3) @(negedge clk);
      rd = 1'b1;
      @(negedge clk) rd = 1'b0;
      check_eq("simul_data_out", data_out, 32'h11112222);
      check_eq("simul_word_count", 32'(word_count), 32'd1);
    end else begin
      repeat (4) @(negedge clk);
    end
    clk_s_d_out = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_sample(input logic [15:0] v, input bit rd_at_write);
    for (int i = 15; i >= 0; i--) begin
      send_bit(v[i], rd_at_write && (i == 0));
    end
  endtask

  task automatic arm(input logic [31:0] n);
    n_samples = n;
    @(negedge clk) enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic disarm();
    @(negedge clk) enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 500; i++) begin
      if (done) break;
      @(negedge clk);
    end
    check_eq("done_wait", 32'(done), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] exp);
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
    check_eq("read_word", data_out, exp);
  endtask

  task automatic pulse_clear();
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    enable      = 1'b0;
    clear       = 1'b0;
    n_samples   = '0;
    clk_s_d_out = 1'b0;
    adc_dout    = 1'b0;
    rd          = 1'b0;

    // Reset values
    #12;
    check_eq("rst_data_out", data_out, 32'h0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    check_eq("rst_status", status(), 32'b100000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pack, even count
    arm(4);
    check_eq("pack_busy", status(), 32'b100010);
    send_sample(16'h1234, 1'b0);
    send_sample(16'hABCD, 1'b0);
    send_sample(16'h0001, 1'b0);
    send_sample(16'hFFFF, 1'b0);
    wait_done();
    check_eq("pack_count", 32'(word_count), 32'd2);
    check_eq("pack_status", status(), 32'b000001);
    do_read(32'h1234ABCD);
    do_read(32'h0001FFFF);
    check_eq("pack_drained", status(), 32'b100001);
    disarm();
    check_eq("pack_idle", status(), 32'b100000);

    // Odd count: last word flushed with zero low half, done with the flush write
    arm(3);
    send_sample(16'h00AA, 1'b0);
    send_sample(16'h00BB, 1'b0);
    send_sample(16'h00CC, 1'b0);
    wait_done();
    repeat (2) @(negedge clk);
    check_eq("odd_cnt_at_done", 32'(rise_cnt), 32'd2);
    check_eq("odd_cnt_before_done", 32'(rise_prev), 32'd1);
    do_read(32'h00AA00BB);
    do_read(32'h00CC0000);
    disarm();

    // Overflow: 6 words into 4 entries
    arm(12);
    for (int i = 0; i < 12; i++) begin
      send_sample(16'h1000 + 16'(i), 1'b0);
    end
    wait_done();
    check_eq("ovf_count", 32'(word_count), 32'd4);
    check_eq("ovf_status", status(), 32'b011001);
    do_read(32'h10001001);
    do_read(32'h10021003);
    do_read(32'h10041005);
    do_read(32'h10061007);
    check_eq("ovf_drained", status(), 32'b101001);
    disarm();

    // Underflow: no pop, data_out kept
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
    check_eq("udf_status", status(), 32'b101100);
    check_eq("udf_data_out", data_out, 32'h10061007);
    pulse_clear();
    check_eq("clr_flags", status(), 32'b100000);

    // Write and pop in the same cycle with one word held
    arm(4);
    send_sample(16'h1111, 1'b0);
    send_sample(16'h2222, 1'b0);
    check_eq("simul_pre_count", 32'(word_count), 32'd1);
    send_sample(16'h3333, 1'b0);
    send_sample(16'h4444, 1'b1);
    wait_done();
    check_eq("simul_no_udf", 32'(underflow), 32'd0);
    do_read(32'h33334444);
    disarm();

    // Abort after 1.5 samples, then re-arm
    arm(4);
    send_sample(16'h1234, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, 1'b0);
    end
    @(negedge clk) enable = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("abort_status", status(), 32'b100000);
    check_eq("abort_count", 32'(word_count), 32'd0);
    arm(2);
    send_sample(16'h5A5A, 1'b0);
    send_sample(16'h0F0F, 1'b0);
    wait_done();
    check_eq("rearm_count", 32'(word_count), 32'd1);
    do_read(32'h5A5A0F0F);
    disarm();

    // Asynchronous reset mid-capture
    arm(4);
    send_sample(16'hCAFE, 1'b0);
    send_sample(16'hBEEF, 1'b0);
    check_eq("rstmid_pre_count", 32'(word_count), 32'd1);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_data_out", data_out, 32'h0);
    check_eq("rstmid_count", 32'(word_count), 32'd0);
    check_eq("rstmid_status", status(), 32'b100000);
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // n_samples = 0: done within 2 cycles, nothing written
    n_samples = 32'd0;
    @(negedge clk) enable = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("zero_status", status(), 32'b100001);
    check_eq("zero_count", 32'(word_count), 32'd0);
    disarm();

    // clear while full and overflowed
    arm(10);
    for (int i = 0; i < 10; i++) begin
      send_sample(16'h2000 + 16'(i), 1'b0);
    end
    wait_done();
    check_eq("full_status", status(), 32'b011001);
    pulse_clear();
    check_eq("clear_count", 32'(word_count), 32'd0);
    check_eq("clear_status", status(), 32'b100000);
    disarm();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
